// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared types and constants for the rv32i fetch front end.
//   fetch_entry_t : one decode-bound entry {pc, instr, fault}
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : addi x0,x0,0, presented with a misaligned-target fault
package rv32_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
//   Two-entry decode buffer: an output register presented to decode plus one
//   skid entry that catches a word arriving while the output is stalled.
//   The fetch issue rule guarantees a free slot for every arriving word, so
//   there is no upstream ready.
// Ports
//   clk, rst_n   clock, async active-low reset
//   flush        drop both entries; a same-cycle in_valid is loaded into out
//   in_valid     entry arriving this cycle
//   in_entry     arriving entry
//   out_ready    decode accepts the output entry this cycle
//   out_valid    output entry present
//   out_entry    output entry (held while out_valid & !out_ready)
//   skid_valid   skid entry occupied (for the fetch occupancy count)
module fetch_skid_buf
    import rv32_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  fetch_entry_t in_entry,
    input  logic         out_ready,
    output logic         out_valid,
    output fetch_entry_t out_entry,
    output logic         skid_valid
);

    fetch_entry_t skid_entry;
    logic         pop;

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_entry  <= '0;
            skid_entry <= '0;
        end else if (flush) begin
            out_valid  <= in_valid;
            skid_valid <= 1'b0;
            if (in_valid) begin
                out_entry <= in_entry;
            end
        end else if (skid_valid) begin
            // Skid is older than any arrival, so it always moves up first.
            if (pop) begin
                out_entry  <= skid_entry;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_entry <= in_entry;
                end
            end
        end else if (!out_valid || pop) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_entry <= in_entry;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_entry <= in_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch front end for the rv32i core. Owns the PC, issues one
//   word address per cycle to instr_mem (1-cycle registered read), and
//   presents {pc, instr} to decode over valid/ready. Redirects from execute
//   flush everything in flight and restart fetch at the target.
// Build option
//   FETCH_MISALIGN_TRAP_EN : a misaligned redirect target produces one fault
//   entry (nop, dec_fault=1) and halts fetch until the next redirect.
//   Undefined: the target's low two bits are cleared and dec_fault stays 0.
// Ports
//   clk, rst_n    clock, async active-low reset
//   imem_addr     byte address to instr_mem (combinational)
//   imem_instr    instr_mem read data, valid the cycle after issue
//   redirect      taken branch/jump strobe from execute
//   redirect_pc   redirect target byte address
//   dec_valid     entry available to decode
//   dec_ready     decode accepts the entry
//   dec_pc        PC of presented entry
//   dec_instr     presented instruction word
//   dec_fault     instruction-address-misaligned marker
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr,
    output logic            dec_fault
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_q;
    logic [XLEN-1:0] target;
    logic            fault_inj;
    logic            halted;
    logic            fire;
    logic            issue;
    logic [1:0]      occ;
    logic            buf_in_valid;
    logic            out_valid;
    logic            skid_valid;
    fetch_entry_t    buf_in_entry;
    fetch_entry_t    out_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted_q;

    assign target    = redirect_pc;
    assign fault_inj = redirect & (redirect_pc[1:0] != 2'b00);
    assign halted    = halted_q;

    // Any redirect clears the halt; a misaligned one re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect) begin
            halted_q <= fault_inj;
        end
    end
`else
    assign target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign fault_inj = 1'b0;
    assign halted    = 1'b0;
`endif

    // A redirect overrides decode's ready: the presented entry is squashed.
    assign fire = out_valid & dec_ready & ~redirect;

    // Occupancy after this cycle's fire must leave room for the word issued now.
    assign occ = 2'(out_valid) + 2'(skid_valid) + 2'(inflight_q);

    always_comb begin
        issue = 1'b0;
        if (redirect) begin
            issue = ~fault_inj;
        end else if (!halted) begin
            issue = (occ - 2'(fire)) < 2'd2;
        end
    end

    assign imem_addr = redirect ? target : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q        <= imem_addr + XLEN'(INSTR_BYTES);
                inflight_pc <= imem_addr;
            end
        end
    end

    // On a redirect the arriving word is dropped; only a fault entry may enter.
    always_comb begin
        buf_in_valid       = redirect ? fault_inj : inflight_q;
        buf_in_entry.pc    = inflight_pc;
        buf_in_entry.instr = imem_instr;
        buf_in_entry.fault = 1'b0;
        if (fault_inj) begin
            buf_in_entry.pc    = redirect_pc;
            buf_in_entry.instr = NOP_INSTR;
            buf_in_entry.fault = 1'b1;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .in_valid   (buf_in_valid),
        .in_entry   (buf_in_entry),
        .out_ready  (dec_ready),
        .out_valid  (out_valid),
        .out_entry  (out_entry),
        .skid_valid (skid_valid)
    );

    assign dec_valid = out_valid;
    assign dec_pc    = out_entry.pc;
    assign dec_instr = out_entry.instr;
    assign dec_fault = out_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with directed scenarios followed by random decode
//   back-pressure and redirects, against an instr_mem model and a stream-level
//   reference: decode must see the PC sequence target, target+4, ... in order,
//   with fixed redirect latency and a full two-entry stall.
module tb_fetch_unit;

    localparam int M_RUN   = 0;
    localparam int M_FAULT = 1;
    localparam int M_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_fault;

    int err_cnt = 0;
    int chk_cnt = 0;

    int          mode = M_RUN;
    int          since = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] tgt = 32'h0;
    logic        prev_ready = 1'b0;
    logic        first_cyc = 1'b0;

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr),
        .dec_fault   (dec_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endfunction

    // instr_mem: registered read of the presented address
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    function automatic logic [31:0] target_of(input logic [31:0] rpc);
`ifdef FETCH_MISALIGN_TRAP_EN
        return rpc;
`else
        return {rpc[31:2], 2'b00};
`endif
    endfunction

    function automatic logic traps(input logic [31:0] rpc);
`ifdef FETCH_MISALIGN_TRAP_EN
        return rpc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic [31:0] t;
        dec_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        if (rd || first_cyc) begin
            t = rd ? target_of(rpc) : 32'h0;
            check_val("issue_addr", imem_addr, t);
            tgt       = t;
            since     = 0;
            first_cyc = 1'b0;
            if (rd && traps(rpc)) begin
                mode   = M_FAULT;
                exp_pc = rpc;
            end else begin
                mode   = M_RUN;
                exp_pc = t;
            end
        end else begin
            if (since < 1000) since++;
            case (mode)
                M_RUN: begin
                    if (since == 1) begin
                        check_val("lat1_valid", 32'(dec_valid), 32'd0);
                        check_val("next_addr", imem_addr, tgt + 32'd4);
                    end else begin
                        check_val("stream_valid", 32'(dec_valid), 32'd1);
                        if (since >= 3 && !rdy && !prev_ready)
                            check_val("stall_addr", imem_addr, exp_pc + 32'd8);
                        if (dec_valid && rdy) begin
                            check_val("dec_pc", dec_pc, exp_pc);
                            check_val("dec_instr", dec_instr, mem_word(exp_pc));
                            check_val("dec_fault", 32'(dec_fault), 32'd0);
                            exp_pc = exp_pc + 32'd4;
                        end
                    end
                end
                M_FAULT: begin
                    check_val("fault_valid", 32'(dec_valid), 32'd1);
                    if (dec_valid && rdy) begin
                        check_val("fault_pc", dec_pc, exp_pc);
                        check_val("fault_instr", dec_instr, 32'h0000_0013);
                        check_val("fault_flag", 32'(dec_fault), 32'd1);
                        mode = M_HALT;
                    end
                end
                default: begin
                    check_val("halt_valid", 32'(dec_valid), 32'd0);
                end
            endcase
        end
        prev_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", 32'(dec_valid), 32'd0);
        check_val("rst_pc", dec_pc, 32'h0);
        check_val("rst_instr", dec_instr, 32'h0);
        check_val("rst_fault", 32'(dec_fault), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        first_cyc = 1'b1;

        // streaming with decode always ready
        repeat (20) run_cycle(1'b1, 1'b0, 32'h0);
        // mid-stream stall and release
        repeat (5) run_cycle(1'b0, 1'b0, 32'h0);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
        // redirect while both entries are held
        repeat (4) run_cycle(1'b0, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 32'h0000_0100);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
        // redirect coinciding with a would-be fire
        run_cycle(1'b1, 1'b1, 32'h0000_0300);
        repeat (5) run_cycle(1'b1, 1'b0, 32'h0);
        // wrap-around
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) run_cycle(1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
        // misaligned target, then resume
        run_cycle(1'b1, 1'b1, 32'h0000_0102);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b1, 32'h0000_0200);
        repeat (6) run_cycle(1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 31) == 0);
            rpc = $urandom;
            case ($urandom_range(0, 3))
                0: rpc = {28'hFFFF_FFF, rpc[3:0]};
                1: rpc = rpc;
                default: rpc = {rpc[31:2], 2'b00};
            endcase
            run_cycle(rdy, rd, rpc);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
